// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, opcode constants and fetch-state encoding
// Contents: INSTR_W/ADDR_W widths, NOP/HALT opcode constants,
//           fetch_state_t enumeration, is_halt() opcode helper.
package mips_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;
  localparam logic [3:0]         HALT_OP  = 4'hF;

  typedef enum logic [1:0] {
    ST_FIRST  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr,
                                   input logic [3:0]         op);
    return instr[INSTR_W-1:INSTR_W-4] == op;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - fetch PC register with redirect/stall/hold priority mux
// Ports: clk, rst_n (async, active-low); redirect, redirect_pc: branch target load;
//        stall: freeze; hold: halted or halt being captured; pc: current fetch PC.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  input  logic              hold,
  output logic [ADDR_W-1:0] pc
);

  // Redirect wins over everything, including stall and halt, so a resolved
  // branch can always pull the fetch stream out of a frozen or halted state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
    end else if (stall || hold) begin
      pc <= pc;
    end else begin
      pc <= pc + ADDR_W'(2);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, IF/ID register and fetch FSM
// Ports: clk, rst_n (async, active-low); stall, redirect, redirect_pc: control;
//        imem_addr/imem_instr: external instruction memory; pc; ifid_instr,
//        ifid_pc_plus2, ifid_valid: IF/ID register; halted: FSM is in HALTED.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC    = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = NOP_WORD,
  parameter logic [3:0]         HALT_OPCODE = HALT_OP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus2,
  output logic               ifid_valid,
  output logic               halted
);

  fetch_state_t      state;
  logic              halt_fetch;
  logic              pc_hold;
  logic [ADDR_W-1:0] pc_plus2;

  assign imem_addr  = pc;
  assign pc_plus2   = pc + ADDR_W'(2);
  assign halt_fetch = is_halt(imem_instr, HALT_OPCODE);
  // The halt word itself is captured, but the PC must not move past it.
  assign pc_hold    = (state == ST_HALTED) || halt_fetch;
  assign halted     = (state == ST_HALTED);

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .hold       (pc_hold),
    .pc         (pc)
  );

  // ifid_pc_plus2 is left untouched on redirect and in HALTED: with valid low
  // its content is meaningless to decode, so there is no point toggling it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_FIRST;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus2 <= '0;
      ifid_valid    <= 1'b0;
    end else if (redirect) begin
      state      <= ST_RUN;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (stall) begin
      state <= state;
    end else if (state == ST_HALTED) begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else begin
      ifid_instr    <= imem_instr;
      ifid_pc_plus2 <= pc_plus2;
      ifid_valid    <= 1'b1;
      state         <= halt_fetch ? ST_HALTED : ST_RUN;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [15:0] RST_PC = 16'h0060;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  logic        frc = 1'b0;
  logic [15:0] fword = 16'h0000;

  // Memory model: word at byte address a is a>>1, unless a word is forced.
  assign imem_instr = frc ? fword : (imem_addr >> 1);

  instruction_fetch #(
    .RESET_PC   (RST_PC),
    .NOP_INSTR  (16'h0000),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus2(ifid_pc_plus2),
    .ifid_valid   (ifid_valid),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_pc2;
  logic        m_valid;
  logic        m_halt;

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 16'h0000; m_pc2 = 16'h0000;
    m_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and push the expected post-edge outputs.
  task automatic drive_push(input logic s, input logic r, input logic [15:0] rpc,
                            input logic f, input logic [15:0] fw);
    logic [15:0] word;
    exp_t        e;
    stall = s; redirect = r; redirect_pc = rpc; frc = f; fword = fw;
    word = f ? fw : (m_pc >> 1);
    if (r) begin
      m_pc = rpc & 16'hFFFE; m_valid = 1'b0; m_instr = 16'h0000; m_halt = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (m_halt) begin
      m_valid = 1'b0; m_instr = 16'h0000;
    end else begin
      m_instr = word; m_pc2 = m_pc + 16'd2; m_valid = 1'b1;
      if (word[15:12] == 4'hF) m_halt = 1'b1;
      else m_pc = m_pc + 16'd2;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc2 = m_pc2; e.valid = m_valid; e.halted = m_halt;
    q.push_back(e);
  endtask

  task automatic step(input logic s, input logic r, input logic [15:0] rpc,
                      input logic f, input logic [15:0] fw);
    @(negedge clk);
    drive_push(s, r, rpc, f, fw);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare DUT outputs after every edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (pc !== e.pc || imem_addr !== e.pc || ifid_instr !== e.instr ||
            ifid_pc_plus2 !== e.pc2 || ifid_valid !== e.valid || halted !== e.halted) begin
          n_bad++;
          $display("FAIL scoreboard @%0t: got pc=%h addr=%h instr=%h pc2=%h v=%b h=%b expected pc=%h instr=%h pc2=%h v=%b h=%b",
                   $time, pc, imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid, halted,
                   e.pc, e.instr, e.pc2, e.valid, e.halted);
        end
      end
    end
  end

  initial begin
    logic [15:0] w;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_pc", pc, RST_PC);
    chk("reset_instr", ifid_instr, 16'h0000);
    chk("reset_pc2", ifid_pc_plus2, 16'h0000);
    chk("reset_valid_halted", {14'b0, ifid_valid, halted}, 16'h0000);

    // Reset release: first edge fetches from RESET_PC
    @(negedge clk);
    rst_n = 1'b1;
    drive_push(0, 0, 0, 0, 0);
    after_edge();
    chk("first_instr", ifid_instr, 16'd48);
    chk("first_pc2", ifid_pc_plus2, 16'h0062);
    chk("first_valid", {15'b0, ifid_valid}, 16'h0001);
    step(0, 0, 0, 0, 0);
    after_edge();
    chk("second_instr", ifid_instr, 16'd49);

    // Stall for three cycles at pc 0x64
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      after_edge();
      chk("stall_pc", pc, 16'h0064);
      chk("stall_instr", ifid_instr, 16'd49);
    end
    step(0, 0, 0, 0, 0);
    after_edge();
    chk("post_stall_instr", ifid_instr, 16'd50);

    // Redirect beats stall, odd target bit dropped
    step(1, 1, 16'h0051, 0, 0);
    after_edge();
    chk("redir_pc", pc, 16'h0050);
    chk("redir_valid", {15'b0, ifid_valid}, 16'h0000);
    step(0, 0, 0, 0, 0);
    after_edge();
    chk("redir_instr", ifid_instr, 16'd40);

    // Halt at 0x10, then redirect to 0 resumes fetch
    step(0, 1, 16'h0010, 0, 0);
    step(0, 0, 0, 1, 16'hF000);
    after_edge();
    chk("halt_capture", ifid_instr, 16'hF000);
    chk("halt_capture_valid", {15'b0, ifid_valid}, 16'h0001);
    chk("halt_flag", {15'b0, halted}, 16'h0001);
    chk("halt_pc", pc, 16'h0010);
    step(0, 0, 0, 0, 0);
    after_edge();
    chk("halted_pc", pc, 16'h0010);
    chk("halted_valid", {15'b0, ifid_valid}, 16'h0000);
    step(0, 1, 16'h0000, 0, 0);
    step(0, 0, 0, 0, 0);
    after_edge();
    chk("resume_halted", {15'b0, halted}, 16'h0000);
    chk("resume_pc", pc, 16'h0002);

    // PC wrap
    step(0, 1, 16'hFFFE, 0, 0);
    step(0, 0, 0, 0, 0);
    after_edge();
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_pc2", ifid_pc_plus2, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:12] = 4'hF;
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom),
           ($urandom_range(0, 19) == 0), w);
    end

    // Async reset while halted
    step(0, 1, 16'h0010, 0, 0);
    step(0, 0, 0, 1, 16'hF123);
    step(1, 0, 0, 0, 0);
    after_edge();
    chk("pre_reset_halted", {15'b0, halted}, 16'h0001);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_pc", pc, RST_PC);
    chk("async_addr", imem_addr, RST_PC);
    chk("async_instr", ifid_instr, 16'h0000);
    chk("async_pc2", ifid_pc_plus2, 16'h0000);
    chk("async_valid_halted", {14'b0, ifid_valid, halted}, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_push(0, 0, 0, 0, 0);
    after_edge();
    chk("restart_instr", ifid_instr, 16'd48);

    #3;
    chk("queue_drained", 16'(q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0000, is the instruction word driven into IF/ID when that register is empty or flushed.
REQ-003 Parameter HALT_OPCODE, default 4'hF, is the value of instr[15:12] that denotes a halt instruction.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stall  input  1  hazard hold; freezes the PC and IF/ID.
REQ-007 redirect  input  1  taken branch or jump resolved downstream.
REQ-008 redirect_pc  input  16  target of the redirect.
REQ-009 imem_addr  output  16  byte address to Instruction_Mem; equal to pc.
REQ-010 imem_instr  input  16  combinational instruction returned for imem_addr.
REQ-011 pc  output  16  current fetch PC.
REQ-012 ifid_instr  output  16  registered instruction for decode.
REQ-013 ifid_pc_plus2  output  16  registered PC+2 of that instruction.
REQ-014 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-015 halted  output  1  the fetch FSM is in HALTED.

Function
REQ-016 Instructions shall be 16 bits wide and byte-addressed, so sequential PC advances by 2; imem_addr shall equal pc combinationally.
REQ-017 PC arithmetic shall be 16-bit modulo: 16'hFFFE + 2 shall give 16'h0000, with no flag.
REQ-018 Bit 0 of redirect_pc shall be forced to 0 when loaded.
REQ-019 The FSM shall have three states: FIRST (the first cycle after reset), RUN and HALTED.
REQ-020 FIRST shall go to RUN unconditionally on the next edge; during FIRST the block fetches normally.
REQ-021 The per-edge priority shall be: redirect > stall > HALTED hold > normal advance.
REQ-022 On redirect: pc <= redirect_pc & 16'hFFFE; ifid_valid <= 0; ifid_instr <= NOP_INSTR; state <= RUN. This applies even when stall=1 or the block is HALTED.
REQ-023 On stall without redirect: pc, ifid_instr, ifid_pc_plus2, ifid_valid and state shall all hold.
REQ-024 Normal advance in FIRST or RUN: pc <= pc+2; ifid_instr <= imem_instr; ifid_pc_plus2 <= pc+2; ifid_valid <= 1.
REQ-025 If a normal-advance capture has imem_instr[15:12] == HALT_OPCODE, the halt word shall be latched into IF/ID with valid=1, state shall go to HALTED, and pc shall hold at the halt address instead of incrementing.
REQ-026 In HALTED without redirect: pc holds; ifid_valid <= 0; ifid_instr <= NOP_INSTR; halted = 1.
REQ-027 The latency from pc to the matching ifid_instr shall be one clock edge; throughput shall be one instruction per cycle when there is no stall.

Reset
REQ-028 While rst_n = 0, regardless of clk: pc = RESET_PC, state = FIRST, ifid_instr = NOP_INSTR, ifid_pc_plus2 = 16'h0000, ifid_valid = 0, halted = 0.
REQ-029 Reset asserted mid-operation, including during HALTED or stall, shall abandon all state immediately.
REQ-030 Fetch shall resume at RESET_PC on the first rising edge after rst_n deasserts.

Structure
REQ-031 The shared package mips_pkg shall hold the INSTR_W/ADDR_W (16) constants, the NOP and HALT opcode constants, and the fetch-state enumeration.
REQ-032 The PC register with its priority mux shall be a single sub-module, pc_reg.
REQ-033 The IF/ID register and the FSM shall live in instruction_fetch.
REQ-034 Instruction_Mem shall remain external and shall not be instantiated inside this block.

Verification
REQ-035 Use a memory model with imem_instr = imem_addr>>1. Scenario: release reset with RESET_PC = 16'h0060 -> after the first edge ifid_instr = 48 (16'h0030), ifid_pc_plus2 = 16'h0062, ifid_valid = 1; after the next edge ifid_instr = 49.
REQ-036 Scenario: stall = 1 for 3 cycles at pc = 16'h0064 -> pc and all IF/ID outputs unchanged for those 3 cycles; the cycle after release captures instruction 50.
REQ-037 Scenario: redirect = 1 with redirect_pc = 16'h0051 while stall = 1 -> pc = 16'h0050, ifid_valid = 0; the next edge gives ifid_instr = 40.
REQ-038 Scenario: force imem_instr = 16'hF000 at pc = 16'h0010 -> ifid_instr = 16'hF000 with valid = 1 on that edge, then halted = 1, pc stays at 16'h0010 and ifid_valid = 0 thereafter; a redirect to 16'h0000 resumes fetch.
REQ-039 Scenario: pc = 16'hFFFE -> the next pc is 16'h0000 and ifid_pc_plus2 = 16'h0000.
REQ-040 Scenario: assert rst_n = 0 asynchronously between edges while HALTED -> all outputs take their reset values immediately, without waiting for a clock edge.
